// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Multi-cycle restoring integer divider for MIPS DIV/DIVU.
//                Performs one trial subtraction per clock, WIDTH iterations,
//                followed by one sign-fixup cycle. The quotient goes to LO
//                and the remainder to HI. The pipeline stalls on busy until
//                done.
//                Optional feature: define SEQ_DIVIDER_SIGNED_EN to compile in
//                signed (DIV) support. Without it every operation is DIVU
//                and is_signed is ignored. Latency is the same either way.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                C_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    localparam logic [1:0] C_S_IDLE = 2'd0;
    localparam logic [1:0] C_S_RUN  = 2'd1;
    localparam logic [1:0] C_S_FIX  = 2'd2;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_acc;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]   r_orig;     // original dividend, returned on divide-by-zero
    logic [C_CNT_W-1:0] r_cnt;

    logic               w_load;
    logic               w_step;
    logic               w_fix;

    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;

    logic               w_dvs_zero;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign w_load = (r_state == C_S_IDLE) && start;
    assign w_step = (r_state == C_S_RUN);
    assign w_fix  = (r_state == C_S_FIX);

    // busy covers RUN and FIX; it drops in the done cycle so a new start is
    // accepted there without a bubble.
    assign busy = (r_state != C_S_IDLE);

    // ------------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------------
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_q_neg;    // quotient sign: XOR of operand signs
    logic r_r_neg;    // remainder sign: follows the dividend

    assign w_dvd_neg = is_signed && dividend[WIDTH-1];
    assign w_dvs_neg = is_signed && divisor[WIDTH-1];
    // The most negative value maps onto itself, which reads correctly as
    // the unsigned magnitude 2^(WIDTH-1).
    assign w_dvd_abs = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_abs = w_dvs_neg ? (~divisor  + 1'b1) : divisor;

    // Capture the result signs alongside the operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_load) begin
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
        end
    end
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_dvd_abs          = dividend;
    assign w_dvs_abs          = divisor;
`endif

    // ------------------------------------------------------------------------
    // Trial subtraction. The shifted remainder is always below twice the
    // divisor, so a WIDTH+1-bit difference is enough: its top bit is the
    // borrow and therefore the "does not fit" flag.
    // ------------------------------------------------------------------------
    assign w_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    // ------------------------------------------------------------------------
    // Result fixup
    // ------------------------------------------------------------------------
    assign w_dvs_zero = (r_dvs == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign w_q_final = w_dvs_zero ? {WIDTH{1'b1}}
                     : (r_q_neg ? (~r_acc + 1'b1) : r_acc);
    assign w_r_final = w_dvs_zero ? r_orig
                     : (r_r_neg ? (~r_rem + 1'b1) : r_rem);
`else
    assign w_q_final = w_dvs_zero ? {WIDTH{1'b1}} : r_acc;
    assign w_r_final = w_dvs_zero ? r_orig : r_rem;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // Hold the current FSM state; reset returns to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= C_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN for WIDTH cycles, one FIX cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_S_IDLE: begin
                if (start) begin
                    w_state_nxt = C_S_RUN;
                end
            end
            C_S_RUN: begin
                if (r_cnt == C_CNT_ONE) begin
                    w_state_nxt = C_S_FIX;
                end
            end
            C_S_FIX: begin
                w_state_nxt = C_S_IDLE;
            end
            default: begin
                w_state_nxt = C_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Load operands on accept, then one restoring step per RUN cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_acc  <= '0;
            r_dvs  <= '0;
            r_orig <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_rem  <= '0;
            r_acc  <= w_dvd_abs;
            r_dvs  <= w_dvs_abs;
            r_orig <= dividend;
            r_cnt  <= C_CNT_INIT;
        end else if (w_step) begin
            r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_acc  <= {r_acc[WIDTH-2:0], w_fits};
            r_cnt  <= r_cnt - C_CNT_ONE;
        end
    end

    // Publish results and pulse done in FIX; results hold until the next FIX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= w_fix;
            if (w_fix) begin
                quotient    <= w_q_final;
                remainder   <= w_r_final;
                div_by_zero <= w_dvs_zero;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider: directed vector table,
//                multi-cycle corner sequences (abort, ignored start,
//                back-to-back) and random operands against an arithmetic
//                reference model. Honors SEQ_DIVIDER_SIGNED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W       = 32;
    localparam int LAT     = W + 2;   // negedges from launch to the done cycle
    localparam int BUSY_N  = W + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero when signed
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        longint sa;
        longint sb;
        bit     s;
`ifdef SEQ_DIVIDER_SIGNED_EN
        s = sgn;
`else
        s = sgn & 1'b0;
`endif
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Called at a negedge: present a start for exactly one edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Called right after launch; returns at the negedge of the done cycle
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input bit edz);
        int lat;
        int bcnt;
        launch(a, b, sgn);
        wait_done(lat, bcnt);
        chk({name, "_latency"}, W'(lat), W'(LAT));
        chk({name, "_busy_cycles"}, W'(bcnt), W'(BUSY_N));
        chk({name, "_busy_in_done"}, W'(busy), '0);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dz"}, W'(div_by_zero), W'(edz));
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        bit           edz;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;
        int           lat;
        int           bcnt;
        int           seen;

        vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
        vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'h0,         1'b0};
        vecs[5] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0};
`else
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'h7FFFFFFC,  32'd1,         1'b0};
        vecs[2] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h0,         32'h80000000,  1'b0};
        vecs[5] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'h0,         32'd7,         1'b0};
`endif
        vecs[3] = '{32'd5,         32'd0,         1'b0, 32'hFFFFFFFF,  32'd5,         1'b1};
        vecs[4] = '{32'hFFFFFFFB,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFFFB,  1'b1};
        vecs[6] = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_q", quotient, '0);
        chk("rst_r", remainder, '0);
        chk("rst_dz", W'(div_by_zero), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            @(negedge clk);
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn,
                      vecs[i].q, vecs[i].r, vecs[i].dz);
        end
        // done is a single pulse and results hold afterwards
        repeat (3) @(negedge clk);
        chk("hold_done_low", W'(done), '0);
        chk("hold_q", quotient, vecs[6].q);

        // Random operands against the model
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1, 2, 3: rb = W'($urandom_range(1, 15));
                4:       rb = '1;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, eq, er, edz);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_check($sformatf("rnd%0d", n), ra, rb, rs, eq, er, edz);
        end

        // start during RUN is ignored: result is for the first operands
        @(negedge clk);
        launch(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(lat, bcnt);
        chk("ign_latency", W'(lat + 5), W'(LAT));
        chk("ign_q", quotient, 32'd14);
        chk("ign_r", remainder, 32'd2);
        @(negedge clk);
        chk("ign_no_second_run", W'(busy), '0);

        // Make outputs non-zero, then abort an operation with reset
        @(negedge clk);
        run_check("pre_abort", 32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1);
        @(negedge clk);
        launch(32'd1000, 32'd10, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_busy_before_rst", W'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_q", quotient, '0);
        chk("abort_r", remainder, '0);
        chk("abort_dz", W'(div_by_zero), '0);
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", W'(seen), '0);
        run_check("post_abort", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

        // Back-to-back: next start asserted in the done cycle
        @(negedge clk);
        launch(32'd50, 32'd5, 1'b0);
        wait_done(lat, bcnt);
        chk("b2b1_latency", W'(lat), W'(LAT));
        chk("b2b1_q", quotient, 32'd10);
        chk("b2b1_r", remainder, 32'd0);
        run_check("b2b2", 32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0);
        repeat (3) @(negedge clk);
        chk("b2b2_hold_q", quotient, 32'h0FFFFFFF);
        chk("b2b2_hold_r", remainder, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
